// File: rtl/ps2_mouse_tracker_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_mouse_tracker_if
//  Description : Bundle between a PS/2 byte source and the mouse tracker.
//                master = byte source / controller side (drives rx_done,
//                rx_data, home); slave = the tracker (drives pointer state).
//  Signals     : rx_done   - one-cycle byte strobe
//                rx_data   - received byte, valid with rx_done
//                home      - recentre pointer, clear wheel
//                x_pos     - pointer X, 0..X_MAX
//                y_pos     - pointer Y, 0..Y_MAX (down = positive)
//                click_l/r/m - button state of last accepted packet
//                wheel     - signed wheel accumulator
//                pkt_valid - one-cycle pulse on packet update
//                drop_cnt  - saturating count of discarded bytes/packets
//  Revision    : 1.0 - initial release
// ============================================================================
interface ps2_mouse_tracker_if #(
  parameter int POS_W = 10
);
  logic             rx_done;
  logic [7:0]       rx_data;
  logic             home;
  logic [POS_W-1:0] x_pos;
  logic [POS_W-1:0] y_pos;
  logic             click_l;
  logic             click_r;
  logic             click_m;
  logic [7:0]       wheel;
  logic             pkt_valid;
  logic [7:0]       drop_cnt;

  modport master (
    output rx_done, rx_data, home,
    input  x_pos, y_pos, click_l, click_r, click_m, wheel, pkt_valid, drop_cnt
  );

  modport slave (
    input  rx_done, rx_data, home,
    output x_pos, y_pos, click_l, click_r, click_m, wheel, pkt_valid, drop_cnt
  );
endinterface
`default_nettype wire

// File: rtl/ps2_mouse_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_mouse_tracker
//  Description : PS/2 mouse packet decoder and pointer tracker. Frames
//                3-byte (or 4-byte wheel) packets from a byte stream,
//                resynchronises on bad headers or inter-byte timeout, and
//                keeps clamped X/Y, button state and a saturating wheel.
//  Ports       : clk_i    - clock, rising edge
//                reset_ni - asynchronous active-low reset
//                bus      - ps2_mouse_tracker_if.slave (byte input, home,
//                           pointer/button/wheel/status outputs)
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_mouse_tracker #(
  parameter int POS_W       = 10,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479,
  parameter int X_INIT      = 320,
  parameter int Y_INIT      = 240,
  parameter int WHEEL_EN    = 0,
  parameter int SCALE_SHIFT = 0,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input logic                clk_i,
  input logic                reset_ni,
  ps2_mouse_tracker_if.slave bus
);

  // Sum width: wide enough that position +/- a 9-bit delta never wraps.
  localparam int CW    = ((POS_W > 9) ? POS_W : 9) + 2;
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic signed [CW-1:0] X_MAX_S = CW'(X_MAX);
  localparam logic signed [CW-1:0] Y_MAX_S = CW'(Y_MAX);
  localparam logic signed [8:0]    W_MAX_S = 9'sd127;
  localparam logic signed [8:0]    W_MIN_S = -9'sd128;

  typedef enum logic [2:0] {
    S_B0  = 3'd0,
    S_B1  = 3'd1,
    S_B2  = 3'd2,
    S_B3  = 3'd3,
    S_UPD = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Latched packet fields
  logic [2:0]       pbtn_q, pbtn_d;
  logic             xs_q, xs_d, ys_q, ys_d, xo_q, xo_d, yo_q, yo_d;
  logic [7:0]       xb_q, xb_d, yb_q, yb_d;
  logic [3:0]       wb_q, wb_d;

  // Output registers
  logic [POS_W-1:0] x_q, x_d, y_q, y_d;
  logic [2:0]       btn_q, btn_d;
  logic [7:0]       wheel_q, wheel_d;
  logic             pv_q, pv_d;
  logic [7:0]       drop_q, drop_d;

  logic             drop_inc_w;

  // Datapath wires
  logic signed [8:0]    dx_raw_w, dy_raw_w, dx_w, dy_w;
  logic signed [CW-1:0] xsum_w, ysum_w;
  logic [POS_W-1:0]     x_new_w, y_new_w;
  logic signed [8:0]    wsum_w;
  logic [7:0]           wheel_new_w;

  // --------------------------------------------------------------------------
  // Framing FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    pbtn_d     = pbtn_q;
    xs_d       = xs_q;
    ys_d       = ys_q;
    xo_d       = xo_q;
    yo_d       = yo_q;
    xb_d       = xb_q;
    yb_d       = yb_q;
    wb_d       = wb_q;
    drop_inc_w = 1'b0;

    case (state_q)
      // UPD behaves like B0 for an incoming byte so a header arriving
      // right after the last byte of a packet is not lost.
      S_B0, S_UPD: begin
        state_d = S_B0;
        tmo_d   = '0;
        if (bus.rx_done) begin
          if (bus.rx_data[3]) begin
            pbtn_d  = bus.rx_data[2:0];
            xs_d    = bus.rx_data[4];
            ys_d    = bus.rx_data[5];
            xo_d    = bus.rx_data[6];
            yo_d    = bus.rx_data[7];
            state_d = S_B1;
          end else begin
            drop_inc_w = 1'b1;
          end
        end
      end

      S_B1, S_B2, S_B3: begin
        if (bus.rx_done) begin
          tmo_d = '0;
          case (state_q)
            S_B1: begin
              xb_d    = bus.rx_data;
              state_d = S_B2;
            end
            S_B2: begin
              yb_d    = bus.rx_data;
              state_d = (WHEEL_EN != 0) ? S_B3 : S_UPD;
            end
            default: begin
              wb_d    = bus.rx_data[3:0];
              state_d = S_UPD;
            end
          endcase
        end else if (tmo_q == TMO_LAST) begin
          // Stalled partial packet: abandon it and count one drop.
          tmo_d      = '0;
          state_d    = S_B0;
          drop_inc_w = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      default: begin
        state_d = S_B0;
        tmo_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Delta, coordinate and wheel arithmetic
  // --------------------------------------------------------------------------
  always_comb begin
    dx_raw_w = $signed({xs_q, xb_q});
    dy_raw_w = $signed({ys_q, yb_q});
    dx_w     = xo_q ? 9'sd0 : (dx_raw_w >>> SCALE_SHIFT);
    dy_w     = yo_q ? 9'sd0 : (dy_raw_w >>> SCALE_SHIFT);

    xsum_w = $signed(CW'(x_q)) + CW'(dx_w);
    // PS/2 +Y is up, screen +Y is down.
    ysum_w = $signed(CW'(y_q)) - CW'(dy_w);

    if (xsum_w < 0)            x_new_w = '0;
    else if (xsum_w > X_MAX_S) x_new_w = POS_W'(X_MAX);
    else                       x_new_w = POS_W'(xsum_w);

    if (ysum_w < 0)            y_new_w = '0;
    else if (ysum_w > Y_MAX_S) y_new_w = POS_W'(Y_MAX);
    else                       y_new_w = POS_W'(ysum_w);

    wsum_w = $signed({wheel_q[7], wheel_q}) + $signed({{5{wb_q[3]}}, wb_q});
    if (wsum_w > W_MAX_S)      wheel_new_w = 8'h7F;
    else if (wsum_w < W_MIN_S) wheel_new_w = 8'h80;
    else                       wheel_new_w = 8'(wsum_w);
  end

  // --------------------------------------------------------------------------
  // Output register next-state
  // --------------------------------------------------------------------------
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    btn_d   = btn_q;
    wheel_d = wheel_q;
    pv_d    = 1'b0;
    drop_d  = drop_q;

    if (state_q == S_UPD) begin
      x_d   = x_new_w;
      y_d   = y_new_w;
      btn_d = pbtn_q;
      pv_d  = 1'b1;
      if (WHEEL_EN != 0) begin
        wheel_d = wheel_new_w;
      end
    end

    // home overrides a simultaneous packet for position and wheel only.
    if (bus.home) begin
      x_d     = POS_W'(X_INIT);
      y_d     = POS_W'(Y_INIT);
      wheel_d = '0;
    end

    if (drop_inc_w && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_B0;
      tmo_q   <= '0;
      pbtn_q  <= '0;
      xs_q    <= 1'b0;
      ys_q    <= 1'b0;
      xo_q    <= 1'b0;
      yo_q    <= 1'b0;
      xb_q    <= '0;
      yb_q    <= '0;
      wb_q    <= '0;
      x_q     <= POS_W'(X_INIT);
      y_q     <= POS_W'(Y_INIT);
      btn_q   <= '0;
      wheel_q <= '0;
      pv_q    <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      pbtn_q  <= pbtn_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      xb_q    <= xb_d;
      yb_q    <= yb_d;
      wb_q    <= wb_d;
      x_q     <= x_d;
      y_q     <= y_d;
      btn_q   <= btn_d;
      wheel_q <= wheel_d;
      pv_q    <= pv_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.x_pos     = x_q;
  assign bus.y_pos     = y_q;
  assign bus.click_l   = btn_q[0];
  assign bus.click_r   = btn_q[1];
  assign bus.click_m   = btn_q[2];
  assign bus.wheel     = wheel_q;
  assign bus.pkt_valid = pv_q;
  assign bus.drop_cnt  = drop_q;

endmodule
`default_nettype wire

// File: doc/ps2_mouse_tracker.md
# ps2_mouse_tracker

Parametrised PS/2 mouse packet decoder and pointer tracker. It sits behind a PS/2 byte receiver and consumes its `rx_done`/`rx_data` byte stream. It frames 3-byte standard or 4-byte wheel packets, resynchronises on bad framing or inter-byte timeout, and maintains clamped screen coordinates, button state and a wheel accumulator. It supersedes the fixed 3-byte packet/XY pair used for the 640x480 pointer path.

## Interface
- `POS_W`, 10, width of `x_pos`/`y_pos`
- `X_MAX`, 639, maximum X coordinate (minimum is 0)
- `Y_MAX`, 479, maximum Y coordinate (minimum is 0)
- `X_INIT`, 320, X after reset or `home`
- `Y_INIT`, 240, Y after reset or `home`
- `WHEEL_EN`, 0, 0 = 3-byte packets; 1 = 4-byte packets, byte 3 carries the wheel
- `SCALE_SHIFT`, 0, deltas are arithmetic-shifted right by this amount before use
- `TIMEOUT_CYC`, 2_000_000, inter-byte timeout in clocks (20 ms at 100 MHz)
- `clk` in 1: the single clock; all logic on the rising edge
- `reset` in 1: asynchronous, active-low; 0 forces the reset state immediately
- `rx_done` in 1: one-cycle strobe; `rx_data` is valid in that cycle
- `rx_data` in 8: received byte
- `home` in 1: synchronous pulse; recenters the pointer and clears the wheel
- `x_pos` out POS_W: pointer X, in 0..X_MAX
- `y_pos` out POS_W: pointer Y, in 0..Y_MAX (screen Y, down = positive)
- `click_l`, `click_r`, `click_m` out 1 each: button state from the last accepted packet
- `wheel` out 8: signed wheel accumulator
- `pkt_valid` out 1: one-cycle pulse when the outputs update from a packet
- `drop_cnt` out 8: saturating count of discarded bytes or partial packets

## Operation
- **States:**
  - `B0`: await header.
  - `B1`: await X byte.
  - `B2`: await Y byte.
  - `B3`: await wheel byte; present only when WHEEL_EN=1.
  - `UPD`: update outputs.
- **`B0`:** on `rx_done`, if `rx_data[3]==1`, latch the header and go to `B1`. Otherwise discard the byte, increment `drop_cnt`, and stay in `B0`.
- **`B1`:** on `rx_done`, latch the X byte and go to `B2`.
- **`B2`:** on `rx_done`, latch the Y byte. Go to `B3` if WHEEL_EN=1, else `UPD`.
- **`B3`:** on `rx_done`, latch the wheel byte and go to `UPD`.
- **Header bit map:** bit 0 = L, bit 1 = R, bit 2 = M, bit 4 = X sign, bit 5 = Y sign, bit 6 = X overflow, bit 7 = Y overflow.
- **Deltas:** `dx = {hdr[4], xbyte}` and `dy = {hdr[5], ybyte}`, each 9-bit two's complement, then `>>> SCALE_SHIFT`.
- **Overflow:** an overflow bit forces that axis delta to 0. The other axis and the buttons still update.
- **Coordinate update:**
  - `x_new = clamp(x + dx, 0, X_MAX)`.
  - `y_new = clamp(y - dy, 0, Y_MAX)`, because PS/2 +Y is up.
  - Compute with at least POS_W+2 signed bits so no intermediate wraps.
- **Wheel:** `wheel += sign_extend(wbyte[3:0])`, saturating at -128 and +127. When WHEEL_EN=0 the wheel is never updated.
- **`UPD`:** lasts exactly one cycle, then returns to `B0`.
  - Registers x, y, buttons and wheel.
  - Pulses `pkt_valid`.
  - An `rx_done` arriving in `UPD` is evaluated as a `B0` header, so no byte is lost.
- **Timeout:** a counter runs in `B1`/`B2`/`B3` and restarts on every accepted byte. If it reaches TIMEOUT_CYC, return to `B0`, discard the partial packet, and increment `drop_cnt` once. The counter is idle in `B0`.
- **`drop_cnt`:** saturates at 255 and never wraps.
- **`home`:** sets x = X_INIT, y = Y_INIT, wheel = 0. It does not change the FSM state or the buttons. If it coincides with an `UPD` cycle, `home` wins for x, y and wheel; buttons and `pkt_valid` still come from the packet.

## Timing
- **Reset values:** state `B0`; `x_pos` = X_INIT; `y_pos` = Y_INIT; `click_*` = 0; `wheel` = 0; `pkt_valid` = 0; `drop_cnt` = 0; timeout counter = 0.
- **Reset mid-packet:** the partial packet is abandoned with no `drop_cnt` increment.
- **Last-byte latency:** if the last byte's `rx_done` is sampled at edge T, the FSM is in `UPD` during cycle T..T+1. Outputs and `pkt_valid=1` are visible after edge T+1, and `pkt_valid` returns to 0 after edge T+2.
- **Output stability:** all outputs are registered and change only on `UPD`, `home` or reset.
- **Inputs:** `rx_done` is assumed to be at most one cycle per byte. No backpressure; every byte is consumed the cycle it arrives.

## Test plan
- **Basic packet:** defaults; bytes 0x09, 0x0A, 0x05 → x_pos=330, y_pos=235, click_l=1, pkt_valid exactly 1 cycle, two edges after the last `rx_done`.
- **Clamping:**
  - From x=100, packet 0x18, 0x00, 0x00 (dx=-256) → x_pos=0.
  - From y=240, packet 0x28, 0x00, 0x00 (dy=-256) → y_pos=479.
- **Resync:**
  - Byte 0x00 first → drop_cnt=1, no pkt_valid.
  - Then 0x0A, 0x01, 0x00 → x+1, click_r=1.
- **Timeout:** 0x08, 0x05, then idle TIMEOUT_CYC cycles → drop_cnt increments by 1, state `B0`. The next packet 0x08, 0x02, 0x00 gives x+2, not a misframed result.
- **Overflow and wheel (WHEEL_EN=1):**
  - 0x48, 0x7F, 0x03, 0x0F → x unchanged, y-3, wheel=-1.
  - 128 packets with wbyte=0x0F → wheel saturates at -128.
- **home and reset:**
  - `home` in the same cycle as `UPD` → x=320, y=240, wheel=0, buttons from the packet, pkt_valid=1.
  - Asserting `reset` low mid-packet → all reset values, with no clock edge required.
